grn_dispatch_rr: RTL

// - Parametrised GRN state-space dispatcher: launches NUM_BLK grn engines over [state_base, state_base+state_count),
//   re-seeds each engine as it finishes, packs {transient, conf} records into LINE_W-bit lines for the host write path.
// - Successor to the fixed 16-block top-level: round-robin service, run-time range, multi-word records, partial-line flush.

---
 rtl/grn_dispatch_rr.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/grn_dispatch_rr.sv
// Round-robin dispatcher that farms a GRN state range out to NUM_BLK engines and packs results into host lines.
// Define GRN_DISPATCH_STATS_EN to add the stat_cycles / stat_stall counters.
module grn_dispatch_rr #(
    parameter int NUM_BLK     = 16,
    parameter int VECTOR_SIZE = 69,
    parameter int LINE_W      = 512,
    parameter int CNT_W       = 32,
    localparam int CONF_WORDS    = (VECTOR_SIZE + 31) / 32,
    localparam int REC_WORDS     = 1 + CONF_WORDS,
    localparam int RECS_PER_LINE = (LINE_W / 32) / REC_WORDS,
    localparam int SLOT_W        = $clog2(RECS_PER_LINE + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [CNT_W-1:0]               state_base,
    input  logic [CNT_W-1:0]               state_count,
    output logic [NUM_BLK-1:0]             blk_start,
    output logic [NUM_BLK*VECTOR_SIZE-1:0] blk_conf,
    input  logic [NUM_BLK-1:0]             blk_done,
    output logic [NUM_BLK-1:0]             blk_ack,
    input  logic [NUM_BLK*VECTOR_SIZE-1:0] blk_conf_out,
    input  logic [NUM_BLK*32-1:0]          blk_trans,
    output logic                           req_write,
    input  logic                           ack_write,
    output logic [LINE_W-1:0]              line_out,
    output logic [SLOT_W-1:0]              line_recs,
    output logic                           busy,
    output logic                           finish
`ifdef GRN_DISPATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]               stat_cycles,
    output logic [CNT_W-1:0]               stat_stall
`endif
);

    localparam int IDX_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam int REC_W = REC_WORDS * 32;

    generate
        if (RECS_PER_LINE < 1 || (LINE_W % 32) != 0 || NUM_BLK < 1 || NUM_BLK > 64) begin : g_bad_cfg
            $error("grn_dispatch_rr: unsupported NUM_BLK/LINE_W/VECTOR_SIZE combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_CAPTURE, S_WRITE, S_FLUSH, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   base_q, count_q, end_q, next_idx, launch_n;
    logic [NUM_BLK-1:0] running, req, grant_oh;
    logic [IDX_W-1:0]   rr_ptr, grant_q, grant_c;
    logic               grant_vld, reseed;
    logic [SLOT_W-1:0]  wr_slot;
    logic [LINE_W-1:0]  line_buf;
    logic [REC_W-1:0]   rec;
    logic               finish_q;

    // First requester at or after the pointer, wrapping; MSB flags a valid grant.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_BLK-1:0] r, input logic [IDX_W-1:0] p);
        logic [IDX_W:0] res;
        int idx;
        res = '0;
        for (int k = NUM_BLK - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NUM_BLK;
            if (r[idx]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    assign launch_n = (count_q < CNT_W'(NUM_BLK)) ? count_q : CNT_W'(NUM_BLK);
    assign req      = blk_done & running;
    assign {grant_vld, grant_c} = rr_pick(req, rr_ptr);
    assign reseed   = (next_idx < end_q);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_oh = '0;
        rec      = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            if (grant_q == IDX_W'(i)) begin
                grant_oh[i]            = 1'b1;
                rec[31:0]              = blk_trans[i*32 +: 32];
                rec[32 +: VECTOR_SIZE] = blk_conf_out[i*VECTOR_SIZE +: VECTOR_SIZE];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = (state_count == '0) ? S_DONE : S_LAUNCH;
            S_LAUNCH:  state_nxt = S_RUN;
            S_RUN: begin
                if (running == '0)  state_nxt = (wr_slot != '0) ? S_FLUSH : S_DONE;
                else if (grant_vld) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = (wr_slot == SLOT_W'(RECS_PER_LINE - 1)) ? S_WRITE : S_RUN;
            S_WRITE:   if (ack_write) state_nxt = S_RUN;
            S_FLUSH:   if (ack_write) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Engine-side strobes decode straight from state so an async reset drops them immediately.
    always_comb begin
        blk_start = '0;
        blk_ack   = '0;
        blk_conf  = '0;
        if (state == S_LAUNCH) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                if (CNT_W'(i) < launch_n) begin
                    blk_start[i] = 1'b1;
                    blk_conf[i*VECTOR_SIZE +: VECTOR_SIZE] = VECTOR_SIZE'(base_q + CNT_W'(i));
                end
            end
        end else if (state == S_CAPTURE) begin
            blk_ack = grant_oh;
            if (reseed) begin
                blk_start = grant_oh;
                for (int i = 0; i < NUM_BLK; i++) begin
                    if (grant_oh[i]) blk_conf[i*VECTOR_SIZE +: VECTOR_SIZE] = VECTOR_SIZE'(next_idx);
                end
            end
        end
    end

    assign req_write = (state == S_WRITE) || (state == S_FLUSH);
    assign line_out  = req_write ? line_buf : '0;
    assign line_recs = (state == S_WRITE) ? SLOT_W'(RECS_PER_LINE) :
                       (state == S_FLUSH) ? wr_slot : '0;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign finish    = finish_q;

    // NOTE: sequential state uses non-blocking assignments only; the line buffer is cleared
    // on reset because FLUSH relies on unused slots reading zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            end_q    <= '0;
            next_idx <= '0;
            running  <= '0;
            rr_ptr   <= '0;
            grant_q  <= '0;
            wr_slot  <= '0;
            line_buf <= '0;
            finish_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (start) begin
                    base_q   <= state_base;
                    count_q  <= state_count;
                    end_q    <= state_base + state_count;
                    rr_ptr   <= '0;
                    finish_q <= 1'b0;
                end
                S_LAUNCH: begin
                    next_idx <= base_q + launch_n;
                    for (int i = 0; i < NUM_BLK; i++) running[i] <= (CNT_W'(i) < launch_n);
                end
                S_RUN: if (running != '0 && grant_vld) begin
                    grant_q <= grant_c;
                    rr_ptr  <= (grant_c == IDX_W'(NUM_BLK - 1)) ? '0 : grant_c + 1'b1;
                end
                S_CAPTURE: begin
                    for (int s = 0; s < RECS_PER_LINE; s++) begin
                        if (wr_slot == SLOT_W'(s)) line_buf[s*REC_W +: REC_W] <= rec;
                    end
                    wr_slot <= wr_slot + 1'b1;
                    if (reseed) next_idx <= next_idx + 1'b1;
                    else        running  <= running & ~grant_oh;
                end
                S_WRITE, S_FLUSH: if (ack_write) begin
                    line_buf <= '0;
                    wr_slot  <= '0;
                end
                S_DONE: finish_q <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef GRN_DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cycles <= '0;
            stat_stall  <= '0;
        end else if (state == S_IDLE && start) begin
            stat_cycles <= '0;
            stat_stall  <= '0;
        end else if (busy) begin
            if (stat_cycles != '1) stat_cycles <= stat_cycles + 1'b1;
            if (req_write && !ack_write && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule
